// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB slave with a 32-bit down-counter timer (reload, one-shot,
// level interrupt) and a programmable number of APB wait states.
// Registers: 0x000 CTRL, 0x004 VALUE, 0x008 RELOAD, 0x00C INTSTATUS (write 1 clears).
// Optional build macro APB_TIMER_PROT_CHECK_EN: unprivileged writes (PPROT[0]=0)
// complete with PSLVERR=1 and leave the registers untouched.
module apb_timer_slave #(
    parameter int unsigned ADDRWIDTH   = 16,
    parameter int unsigned DATAWIDTH   = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 PCLKEN,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic                 PWRITE,
    input  logic [DATAWIDTH-1:0] PWDATA,
    input  logic [2:0]           PPROT,
    input  logic [3:0]           PSTRB,
    output logic [DATAWIDTH-1:0] PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic                 TIMERINT
);

    localparam logic StIdle   = 1'b0;
    localparam logic StAccess = 1'b1;

    logic        state_q, state_d;
    logic [1:0]  wait_q, wait_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] value_q, value_d;
    logic [31:0] reload_q, reload_d;
    logic        int_q, int_d;
    logic        expired_q, expired_d;

    logic [9:0]  reg_idx;
    logic        sel_ctrl, sel_value, sel_reload, sel_int, addr_ok;
    logic        prot_err;
    logic        xfer_done, commit, wr_en;
    logic        count_en, hw_set;
    logic [31:0] rdata;
    logic        unused_inputs;

    assign unused_inputs = ^{PADDR[ADDRWIDTH-1:12], PADDR[1:0], PPROT};

    assign reg_idx    = PADDR[11:2];
    assign sel_ctrl   = (reg_idx == 10'd0);
    assign sel_value  = (reg_idx == 10'd1);
    assign sel_reload = (reg_idx == 10'd2);
    assign sel_int    = (reg_idx == 10'd3);
    assign addr_ok    = (reg_idx[9:2] == 8'd0);

`ifdef APB_TIMER_PROT_CHECK_EN
    assign prot_err = PWRITE & ~PPROT[0];
`else
    assign prot_err = 1'b0;
`endif

    // Final access cycle: this is where PREADY rises and the write lands.
    assign xfer_done = (state_q == StAccess) && (wait_q == 2'd0);
    assign commit    = xfer_done & PCLKEN & PSEL & PENABLE;
    assign wr_en     = commit & PWRITE & addr_ok & ~prot_err;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    // APB handshake: setup -> access with WAIT_STATES stalls, only on PCLKEN cycles.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        if (PCLKEN) begin
            case (state_q)
                StIdle: begin
                    if (PSEL && !PENABLE) begin
                        state_d = StAccess;
                        wait_d  = 2'(WAIT_STATES);
                    end
                end
                StAccess: begin
                    if (!PSEL || !PENABLE) begin
                        state_d = StIdle;  // protocol violation: abort, nothing committed
                    end else if (wait_q != 2'd0) begin
                        wait_d = wait_q - 2'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Timer step plus register writes; APB writes override hardware updates.
    always_comb begin
        value_d   = value_q;
        reload_d  = reload_q;
        ctrl_d    = ctrl_q;
        // Clearing enable through CTRL halts counting in the very cycle of the write.
        count_en  = ctrl_q[0] & ~(wr_en & sel_ctrl & PSTRB[0] & ~PWDATA[0]);
        hw_set    = 1'b0;
        if (count_en) begin
            if (expired_q) begin
                if (ctrl_q[2]) ctrl_d[0] = 1'b0;
                else           value_d   = reload_q;
            end else if (value_q != 32'd0) begin
                value_d = value_q - 32'd1;
                // A VALUE write suppresses the decrement, so it also suppresses the expiry.
                hw_set  = (value_q == 32'd1) & ~(wr_en & sel_value);
            end
        end
        expired_d = hw_set;
        if (wr_en) begin
            if (sel_value)             value_d  = lane_merge(value_q, PWDATA, PSTRB);
            if (sel_reload)            reload_d = lane_merge(reload_q, PWDATA, PSTRB);
            if (sel_ctrl && PSTRB[0])  ctrl_d   = PWDATA[2:0];
        end
        int_d = hw_set | (int_q & ~(wr_en & sel_int & PSTRB[0] & PWDATA[0]));
    end

    // Read mux for the addressed register.
    always_comb begin
        rdata = 32'd0;
        case (reg_idx)
            10'd0:   rdata = {29'd0, ctrl_q};
            10'd1:   rdata = value_q;
            10'd2:   rdata = reload_q;
            10'd3:   rdata = {31'd0, int_q};
            default: rdata = 32'd0;
        endcase
    end

    assign PREADY   = (state_q == StIdle) | (wait_q == 2'd0);
    assign PSLVERR  = xfer_done & (~addr_ok | prot_err);
    assign PRDATA   = (xfer_done && !PWRITE) ? rdata : 32'd0;
    assign TIMERINT = int_q & ctrl_q[1];

    // APB handshake state.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= StIdle;
            wait_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Timer and register state.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ctrl_q    <= 3'd0;
            value_q   <= 32'd0;
            reload_q  <= 32'd0;
            int_q     <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            value_q   <= value_d;
            reload_q  <= reload_d;
            int_q     <= int_d;
            expired_q <= expired_d;
        end
    end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: two instances (zero wait states and two wait states),
// directed scenarios followed by randomized transfers, checked against a
// behavioural model through an expected-response queue.
module tb_apb_timer_slave;

    logic              clk = 1'b0;
    logic              hreset;
    logic              pclken;
    logic [1:0]        psel, penable, pwrite;
    logic [1:0][15:0]  paddr;
    logic [1:0][31:0]  pwdata;
    logic [1:0][2:0]   pprot;
    logic [1:0][3:0]   pstrb;
    logic [1:0][31:0]  prdata;
    logic [1:0]        pready, pslverr, timerint;

    always #5 clk = ~clk;

    apb_timer_slave #(.ADDRWIDTH(16), .DATAWIDTH(32), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(hreset), .PCLKEN(pclken), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PADDR(paddr[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]), .PPROT(pprot[0]),
        .PSTRB(pstrb[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
        .TIMERINT(timerint[0])
    );

    apb_timer_slave #(.ADDRWIDTH(16), .DATAWIDTH(32), .WAIT_STATES(2)) u_dut2 (
        .HCLK(clk), .HRESET(hreset), .PCLKEN(pclken), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PADDR(paddr[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]), .PPROT(pprot[1]),
        .PSTRB(pstrb[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
        .TIMERINT(timerint[1])
    );

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        slverr;
        int          waits;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   pk_mode;
    logic tog;

    // Behavioural model state, one set per instance.
    logic [1:0][31:0] m_val, m_rel;
    logic [1:0][2:0]  m_ctrl;
    logic [1:0]       m_int, m_exp;
    // Write the driver has committed in the current cycle (applied at the next edge).
    logic [1:0]       c_wr;
    logic [1:0][9:0]  c_idx;
    logic [1:0][31:0] c_data;
    logic [1:0][3:0]  c_strb;

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Model: one timer tick per clock, then any committed APB write on top.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [31:0] nv, nr;
            logic [2:0]  nc;
            logic        ni, fire, run, vwr;
            if (hreset) begin
                m_val[d] <= '0; m_rel[d] <= '0; m_ctrl[d] <= '0; m_int[d] <= 1'b0;
                m_exp[d] <= 1'b0;
            end else begin
                nv = m_val[d]; nr = m_rel[d]; nc = m_ctrl[d]; ni = m_int[d]; fire = 1'b0;
                run = nc[0] && !(c_wr[d] && c_idx[d] == 10'd0 && c_strb[d][0] && !c_data[d][0]);
                vwr = c_wr[d] && c_idx[d] == 10'd1;
                if (run && m_exp[d]) begin
                    if (nc[2]) nc[0] = 1'b0;
                    else       nv = nr;
                end else if (run && nv != 0 && !vwr) begin
                    nv   = nv - 1;
                    fire = (nv == 0);
                end
                if (c_wr[d]) begin
                    case (c_idx[d])
                        10'd0: if (c_strb[d][0]) nc = c_data[d][2:0];
                        10'd1: nv = lanes(m_val[d], c_data[d], c_strb[d]);
                        10'd2: nr = lanes(m_rel[d], c_data[d], c_strb[d]);
                        10'd3: if (c_strb[d][0] && c_data[d][0]) ni = 1'b0;
                        default: ;
                    endcase
                end
                if (fire) ni = 1'b1;
                m_val[d] <= nv; m_rel[d] <= nr; m_ctrl[d] <= nc; m_int[d] <= ni;
                m_exp[d] <= fire;
            end
        end
    end

    function automatic logic [31:0] m_read(input int d, input logic [9:0] idx);
        case (idx)
            10'd0:   return {29'd0, m_ctrl[d]};
            10'd1:   return m_val[d];
            10'd2:   return m_rel[d];
            10'd3:   return {31'd0, m_int[d]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_prot_err(input logic wr, input logic [2:0] prot);
`ifdef APB_TIMER_PROT_CHECK_EN
        return wr && !prot[0];
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_pclken(output logic p);
        case (pk_mode)
            0:       p = 1'b1;
            1:       begin tog = ~tog; p = tog; end
            default: p = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One APB transfer. The number of stalls is known from the instance's WAIT_STATES,
    // so the commit cycle is predicted by the bench, not observed from the DUT.
    task automatic apb_xfer(input int d, input logic wr, input logic [15:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, input bit abort,
                            input bit use_exp, input logic [31:0] exp_rd);
        logic       p;
        int         waits, ws;
        logic [9:0] idx;
        exp_t       e;
        bit         perr;
        ws  = (d == 0) ? 0 : 2;
        idx = addr[11:2];
        psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = addr; pwrite[d] = wr;
        pwdata[d] = data; pstrb[d] = strb; pprot[d] = prot;
        do begin
            next_pclken(p); pclken = p; @(posedge clk); #1;
        end while (!p);
        penable[d] = 1'b1;
        waits = 0;
        forever begin
            next_pclken(p); pclken = p;
            if (p && abort) begin
                psel[d] = 1'b0; penable[d] = 1'b0;
                @(posedge clk); #1;
                break;
            end
            if (p && waits == ws) begin
                perr     = m_prot_err(wr, prot);
                e.d      = d;
                e.waits  = ws;
                e.slverr = (idx > 10'd3) || perr;
                e.rdata  = wr ? 32'd0 : (use_exp ? exp_rd : m_read(d, idx));
                sbq.push_back(e);
                if (wr && idx <= 10'd3 && !perr) begin
                    c_wr[d] = 1'b1; c_idx[d] = idx; c_data[d] = data; c_strb[d] = strb;
                end
                @(posedge clk); #1;
                c_wr[d] = 1'b0;
                break;
            end
            if (p) waits++;
            @(posedge clk); #1;
        end
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic wr32(input int d, input logic [15:0] a, input logic [31:0] v,
                        input logic [3:0] s = 4'hF, input logic [2:0] prot = 3'b001);
        apb_xfer(d, 1'b1, a, v, s, prot, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic rd32(input int d, input logic [15:0] a, input bit use_exp = 1'b0,
                        input logic [31:0] exp_rd = 32'd0);
        apb_xfer(d, 1'b0, a, 32'd0, 4'hF, 3'b001, 1'b0, use_exp, exp_rd);
    endtask

    // Monitor: TIMERINT every cycle, and each completed transfer against the queue.
    task automatic monitor();
        int   low [2];
        exp_t e;
        low[0] = 0; low[1] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d timerint", d), {31'd0, timerint[d]},
                      {31'd0, m_int[d] & m_ctrl[d][1]});
                if (!psel[d]) low[d] = 0;
                if (pclken && psel[d] && penable[d]) begin
                    if (pready[d]) begin
                        if (sbq.size() == 0) begin
                            check($sformatf("d%0d unexpected completion", d), 32'd1, 32'd0);
                        end else begin
                            e = sbq.pop_front();
                            check($sformatf("d%0d instance", d), d, e.d);
                            check($sformatf("d%0d prdata @%h", d, paddr[d]), prdata[d], e.rdata);
                            check($sformatf("d%0d pslverr @%h", d, paddr[d]),
                                  {31'd0, pslverr[d]}, {31'd0, e.slverr});
                            check($sformatf("d%0d wait cycles", d), low[d], e.waits);
                        end
                        low[d] = 0;
                    end else begin
                        low[d]++;
                    end
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic        wr;
        int          d;
        bit          abort;

        hreset = 1'b1; pclken = 1'b1; psel = '0; penable = '0; pwrite = '0; paddr = '0;
        pwdata = '0; pprot = '0; pstrb = '0; c_wr = '0; c_idx = '0; c_data = '0;
        c_strb = '0; tog = 1'b0; pk_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        hreset = 1'b0;

        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d reset pready", i), {31'd0, pready[i]}, 32'd1);
            check($sformatf("d%0d reset prdata", i), prdata[i], 32'd0);
            check($sformatf("d%0d reset pslverr", i), {31'd0, pslverr[i]}, 32'd0);
            check($sformatf("d%0d reset timerint", i), {31'd0, timerint[i]}, 32'd0);
        end
        fork
            monitor();
        join_none

        // Register reset values, zero wait states.
        pk_mode = 0;
        for (int i = 0; i < 4; i++) rd32(0, 16'(i * 4), 1'b1, 32'd0);

        // Two wait states with PCLKEN toggling.
        pk_mode = 1;
        wr32(1, 16'h0008, 32'h0000_00FF);
        rd32(1, 16'h0008, 1'b1, 32'h0000_00FF);

        // Periodic timer: interrupt three cycles after enabling, then reload.
        pk_mode = 0;
        wr32(0, 16'h0004, 32'd3);
        wr32(0, 16'h0008, 32'd5);
        wr32(0, 16'h0000, 32'h3);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("irq rise k=%0d", k), {31'd0, timerint[0]}, (k == 3) ? 32'd1 : 32'd0);
            if (k < 3) idle(1);
        end
        idle(3);
        rd32(0, 16'h0004);
        wr32(0, 16'h000C, 32'h1);
        idle(8);
        wr32(0, 16'h0000, 32'h0);
        wr32(0, 16'h000C, 32'h1);

        // One-shot.
        wr32(0, 16'h0004, 32'd2);
        wr32(0, 16'h0000, 32'h7);
        idle(6);
        rd32(0, 16'h000C, 1'b1, 32'd1);
        rd32(0, 16'h0000, 1'b1, 32'd6);
        rd32(0, 16'h0004, 1'b1, 32'd0);
        wr32(0, 16'h0000, 32'h0);
        wr32(0, 16'h000C, 32'h1);

        // Byte strobes and an unmapped offset.
        wr32(0, 16'h0004, 32'hFFFF_FFFF);
        wr32(0, 16'h0004, 32'h1234_5678, 4'b0101);
        rd32(0, 16'h0004, 1'b1, 32'hFF34_FF78);
        rd32(0, 16'h0010, 1'b1, 32'd0);
        wr32(0, 16'h0010, 32'hDEAD_BEEF);

        // Write-1-clear lands on the same edge as the 1->0 expiry.
        wr32(0, 16'h0008, 32'd0);
        wr32(0, 16'h0004, 32'd2);
        wr32(0, 16'h0000, 32'h1);
        wr32(0, 16'h000C, 32'h1);
        rd32(0, 16'h000C, 1'b1, 32'd1);
`ifdef APB_TIMER_PROT_CHECK_EN
        wr32(0, 16'h0000, 32'h0, 4'hF, 3'b000);
        rd32(0, 16'h0000, 1'b1, 32'd1);
`endif
        wr32(0, 16'h0000, 32'h0);
        wr32(0, 16'h000C, 32'h1);

        // Randomized traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            d       = int'($urandom_range(0, 1));
            pk_mode = int'($urandom_range(0, 2));
            wr      = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       addr = 16'h0000;
                1:       addr = 16'h0004;
                2:       addr = 16'h0008;
                3:       addr = 16'h000C;
                4:       addr = 16'h0010;
                default: addr = 16'($urandom);
            endcase
            data  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 9)) : $urandom;
            strb  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            prot  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b001;
            abort = ($urandom_range(0, 9) == 0);
            apb_xfer(d, wr, addr, data, strb, prot, abort, 1'b0, 32'd0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 5)));
        end

        idle(5);
        check("scoreboard drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
